// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: data-memory req/ack access, load alignment,
// store lane steering, MEM/WB register and branch/jump redirect. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       rs2_val,
    input  logic [31:0]       ia_add4,
    input  logic [31:0]       comp_result,
    input  logic [2:0]        mem_op,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              jmp,
    input  logic [4:0]        rd,
    input  logic              wb_enable,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic [31:0]       wb_data,
    output logic              redirect,
    output logic [31:0]       redirect_target
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [31:0]       r_dmem_wdata;
    logic [3:0]        r_dmem_be;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic              r_wb_we;
    logic [31:0]       r_wb_data;
    logic              r_redirect;
    logic [31:0]       r_redirect_target;

    logic [1:0]  w_a;
    logic        w_is_mem;
    logic        w_trap;
    logic        w_start;
    logic [3:0]  w_store_be;
    logic [31:0] w_store_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_wb_we;
    logic        w_redirect;
    logic [31:0] w_target;

    assign w_a      = alu_result[1:0];
    assign w_is_mem = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    // H/HU straddling a word, or W not on a word boundary.
    assign w_misaligned = ((mem_op[1:0] == 2'b01) && (w_a == 2'd3)) ||
                          ((mem_op == 3'b010) && (w_a != 2'd0));
    assign w_trap       = in_valid & w_is_mem & w_misaligned;
    assign misalign     = r_misalign;
`else
    assign w_trap = 1'b0;
`endif

    assign w_start = in_valid & w_is_mem & ~w_trap;

    // Store lane steering; codes other than B/H fall back to a full word.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_store_be    = 4'b1111;
        w_store_wdata = rs2_val;
        case (mem_op)
            3'b000: begin
                w_store_be    = 4'b0001 << w_a;
                w_store_wdata = {4{rs2_val[7:0]}};
            end
            3'b001: begin
                w_store_be    = 4'b0011 << w_a;
                w_store_wdata = {2{rs2_val[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = dmem_rdata >> {w_a, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (mem_op)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

    assign w_wb_data  = mem_read ? w_load_data : (jmp ? ia_add4 : alu_result);
    assign w_wb_we    = wb_enable & (rd != 5'd0) & ~mem_write;
    assign w_redirect = jmp | (branch & comp_result[0]);
    assign w_target   = {alu_result[31:1], 1'b0};

    // Execute holds its inputs while stalled, so the ack cycle still sees the original op.
    assign stall = (r_state == S_IDLE) ? w_start : ~dmem_ack;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_dmem_req        <= 1'b0;
            r_dmem_we         <= 1'b0;
            r_dmem_addr       <= '0;
            r_dmem_wdata      <= '0;
            r_dmem_be         <= '0;
            r_wb_valid        <= 1'b0;
            r_wb_rd           <= '0;
            r_wb_we           <= 1'b0;
            r_wb_data         <= '0;
            r_redirect        <= 1'b0;
            r_redirect_target <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state      <= S_REQ;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= mem_write;
                        r_dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                        r_dmem_wdata <= w_store_wdata;
                        r_dmem_be    <= w_store_be;
                        r_wb_valid   <= 1'b0;
                        r_wb_we      <= 1'b0;
                        r_redirect   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        r_misalign   <= 1'b0;
`endif
                    end else begin
                        r_wb_valid        <= in_valid;
                        r_wb_rd           <= rd;
                        r_wb_we           <= in_valid & w_wb_we & ~w_trap;
                        r_wb_data         <= w_wb_data;
                        r_redirect        <= in_valid & w_redirect;
                        r_redirect_target <= w_target;
`ifdef MEM_MISALIGN_TRAP_EN
                        r_misalign        <= w_trap;
`endif
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_state           <= S_IDLE;
                        r_dmem_req        <= 1'b0;
                        r_dmem_we         <= 1'b0;
                        r_wb_valid        <= 1'b1;
                        r_wb_rd           <= rd;
                        r_wb_we           <= w_wb_we;
                        r_wb_data         <= w_wb_data;
                        r_redirect        <= w_redirect;
                        r_redirect_target <= w_target;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req        = r_dmem_req;
    assign dmem_we         = r_dmem_we;
    assign dmem_addr       = r_dmem_addr;
    assign dmem_wdata      = r_dmem_wdata;
    assign dmem_be         = r_dmem_be;
    assign wb_valid        = r_wb_valid;
    assign wb_rd           = r_wb_rd;
    assign wb_we           = r_wb_we;
    assign wb_data         = r_wb_data;
    assign redirect        = r_redirect;
    assign redirect_target = r_redirect_target;

endmodule
